rr_priority_encoder: RTL
========================

Name: rr_priority_encoder

Overview:
- Parametrised successor to the team's 4-to-2 one-hot encoder.
- Encodes an N-bit request vector into a binary index, with a registered output and valid/ready handshakes on both sides.
- Supports fixed LSB-first priority and round-robin priority, selectable at runtime.
- Defined results for zero-hot and multi-hot inputs.
- Used as the grant encoder in front of shared-resource arbiters.

Parameters:
- N, 4, number of request lines; legal range N >= 2, not required to be a power of 2.
- W, $clog2(N), index width; derived, not to be overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request vector on req is valid.
- in_ready  output  1  block can accept a vector this cycle.
- req  input  N  request vector; bit i means requester i is requesting.
- mode  input  1  0 = fixed priority (lowest index wins); 1 = round-robin. Sampled on accept.
- out_valid  output  1  out_* fields hold a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- out_idx  output  W  encoded winning index.
- out_none  output  1  accepted vector was all zeros.
- out_multi  output  1  accepted vector had more than one bit set.

Behaviour:
- Clock and reset: one clock domain, clk; reset is asynchronous, active-low, on rst_n.
- Reset values: out_valid=0, out_idx=0, out_none=0, out_multi=0, internal pointer ptr=0. Reset takes effect immediately, independent of clk. Any in-flight result is discarded.
- Pipeline:
  - One output register stage.
  - in_ready = !out_valid || out_ready (combinational).
  - Accept occurs when in_valid && in_ready.
  - Result is visible on out_* with out_valid=1 in the cycle after accept (latency 1).
  - Full throughput: back-to-back accepts are allowed while out_ready=1.
- Output hold: while out_valid && !out_ready, all out_* stay stable and in_ready=0.
- Output release: if out_ready=1 and there is no accept in the same cycle, out_valid drops to 0 next cycle. out_idx, out_none and out_multi keep their last values.
- Fixed mode (mode=0):
  - out_idx = lowest i with req[i]=1.
  - ptr is not modified.
- Round-robin mode (mode=1):
  - out_idx = first i with req[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - On accept with req != 0, ptr <= (out_idx+1) mod N. When out_idx = N-1, ptr wraps to 0, including for non-power-of-2 N.
- Zero-hot: req=0 gives out_idx=0, out_none=1, out_multi=0; ptr unchanged in either mode.
- Multi-hot: out_multi=1 iff popcount(req) >= 2. The winner is chosen per mode; there is no X output.
- Mode switching: mode is sampled per accept. Switching mode does not reset ptr; fixed-mode accepts leave ptr at its last round-robin value.
- No combinational path from req or mode to out_*; all outputs are registered except in_ready.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid, out_idx, out_none and out_multi go to 0 immediately without a clock edge. After release, the first RR accept of req=4'b1111 -> out_idx=0.
- Fixed one-hot sweep, mode=0: req = 0001, 0010, 0100, 1000 back-to-back with out_ready=1 -> out_idx = 0, 1, 2, 3, each one cycle after accept, out_multi=0, out_none=0, in_ready held at 1.
- Multi-hot and zero-hot, mode=0: req=4'b1010 -> out_idx=1, out_multi=1. Then req=4'b0000 -> out_idx=0, out_none=1, out_multi=0.
- Round-robin rotation, mode=1: req=4'b1111 accepted four times -> out_idx = 0, 1, 2, 3, then 0. Then req=4'b0101 with ptr=1 -> out_idx=2, ptr=3. Then req=4'b0101 -> out_idx=0 (wrap).
- Backpressure: hold out_ready=0 with out_valid=1 for 3 cycles while in_valid=1 with a changing req -> in_ready=0, out_* stable, ptr unchanged. Raise out_ready -> the pending input is accepted that cycle and its result appears the next cycle.
- Non-power-of-2 wrap, N=5 (W=3), mode=1: req=5'b10001 accepted twice -> out_idx=0, then 4, then ptr=0. A third accept -> out_idx=0.

Source files
------------

// File: rtl/rr_priority_encoder.sv
// ============================================================================
// Module   : rr_priority_encoder
// Purpose  : N-bit request vector to binary index encoder with fixed or
//            round-robin priority, registered output, valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_encoder #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] req,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_none,
  output logic         out_multi
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_idx_q,   out_idx_d;
  logic         out_none_q,  out_none_d;
  logic         out_multi_q, out_multi_d;
  logic [W-1:0] ptr_q,       ptr_d;

  logic           accept;
  logic           any_req;
  logic           multi_req;
  logic [W-1:0]   fixed_idx;
  logic [W-1:0]   rr_idx;
  logic           rr_found;
  logic [W-1:0]   sel_idx;
  logic [W-1:0]   ptr_next;
  logic [2*N-1:0] req_dbl;
  int             pos;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign any_req   = |req;
  // Clearing the lowest set bit leaves something behind only if two or more were set.
  assign multi_req = |(req & (req - N'(1)));
  assign req_dbl   = {req, req};

  always_comb begin
    fixed_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) fixed_idx = W'(i);
    end
  end

  // Scan the doubled vector from ptr so the wrap-around needs no modulo logic.
  always_comb begin
    rr_idx   = '0;
    rr_found = 1'b0;
    pos      = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr_q) + k;
      if (!rr_found && req_dbl[pos]) begin
        rr_found = 1'b1;
        rr_idx   = (pos >= N) ? W'(pos - N) : W'(pos);
      end
    end
  end

  assign sel_idx  = mode ? rr_idx : fixed_idx;
  assign ptr_next = (rr_idx == W'(N - 1)) ? '0 : rr_idx + W'(1);

  always_comb begin
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_none_d  = out_none_q;
    out_multi_d = out_multi_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_idx_d   = sel_idx;
      out_none_d  = !any_req;
      out_multi_d = multi_req;
      if (mode && any_req) ptr_d = ptr_next;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_none_q  <= 1'b0;
      out_multi_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_none_q  <= out_none_d;
      out_multi_q <= out_multi_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_none  = out_none_q;
  assign out_multi = out_multi_q;

endmodule

`default_nettype wire
